// File: rtl/countdown_timer_param.sv
// N-digit BCD countdown timer with debounced key entry and a scanned, registered 7-segment driver.
// Key events act one cycle after release is seen (after a 2-flop sync); display outputs lag state by one cycle.
module countdown_timer_param #(
  parameter int NDIG      = 6,
  parameter int SCAN_DIV  = 100000,
  parameter int DEB_CYC   = 1000000,
  parameter int TICK_DIV  = 50000000,
  parameter int PAUSE_EN  = 1,
  parameter int MMSS_MODE = 0,
  parameter int ALARM_TMO = 0
) (
  input  logic            clkin,
  input  logic            rst,
  input  logic            ke,
  input  logic            ku,
  input  logic            kd,
  input  logic            kl,
  input  logic            kr,
  output logic [NDIG-1:0] sel_n,
  output logic [7:0]      seg,
  output logic            alarm_n,
  output logic [2:0]      state_o
);

  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int AW = (ALARM_TMO > 1) ? $clog2(ALARM_TMO) : 1;

  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYC);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(TICK_DIV / 2);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CUR_MAX  = CW'(NDIG - 1);
  localparam logic [AW-1:0] TMO_LAST = AW'((ALARM_TMO > 0) ? ALARM_TMO - 1 : 0);
  localparam logic [NDIG-1:0] SEL_ONE = {{(NDIG-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_ALARM = 3'd4
  } state_t;

  function automatic logic [3:0] dig_lim(input int i);
    if (MMSS_MODE != 0 && (i == 1 || i == 3)) return 4'd5;
    return 4'd9;
  endfunction

  function automatic logic [7:0] seg_lut(input logic [3:0] d);
    case (d)
      4'd0: seg_lut = 8'hC0;
      4'd1: seg_lut = 8'hF9;
      4'd2: seg_lut = 8'hA4;
      4'd3: seg_lut = 8'hB0;
      4'd4: seg_lut = 8'h99;
      4'd5: seg_lut = 8'h92;
      4'd6: seg_lut = 8'h82;
      4'd7: seg_lut = 8'hF8;
      4'd8: seg_lut = 8'h80;
      4'd9: seg_lut = 8'h90;
      default: seg_lut = 8'hFF;
    endcase
  endfunction

  // Key order {ke, kl, kr, ku, kd} doubles as event priority, MSB first.
  logic [4:0]    key_raw, key_s1, key_s2, ev;
  logic [DW-1:0] deb_cnt [5];
  logic          ev_e, ev_l, ev_r, ev_u, ev_d;

  assign key_raw = {ke, kl, kr, ku, kd};

  always_ff @(posedge clkin) begin
    if (rst) begin
      key_s1 <= '1;
      key_s2 <= '1;
      for (int k = 0; k < 5; k++) deb_cnt[k] <= '0;
    end else begin
      key_s1 <= key_raw;
      key_s2 <= key_s1;
      for (int k = 0; k < 5; k++) begin
        if (!key_s2[k]) begin
          if (deb_cnt[k] != DEB_MAX) deb_cnt[k] <= deb_cnt[k] + 1'b1;
        end else begin
          deb_cnt[k] <= '0;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 5; k++) ev[k] = key_s2[k] && (deb_cnt[k] == DEB_MAX);
  end

  assign ev_e = ev[4];
  assign ev_l = ev[3] & ~ev[4];
  assign ev_r = ev[2] & ~|ev[4:3];
  assign ev_u = ev[1] & ~|ev[4:2];
  assign ev_d = ev[0] & ~|ev[4:1];

  state_t             state, nxt_state;
  logic [4*NDIG-1:0]  val, nxt_val, dec_val;
  logic [CW-1:0]      cursor, nxt_cur;
  logic [TW-1:0]      tick_cnt, nxt_tick;
  logic [AW-1:0]      tmo_cnt, nxt_tmo;
  logic [3:0]         cur_d, cur_lim;
  logic               borrow;
  logic               tick_end;

  assign tick_end = (tick_cnt == TICK_MAX);
  assign cur_d    = val[4*int'(cursor) +: 4];
  assign cur_lim  = dig_lim(int'(cursor));

  // Borrow ripples from the LSD; a zero digit reloads to its own limit.
  always_comb begin
    dec_val = val;
    borrow  = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (borrow) begin
        if (val[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = dig_lim(i);
        end else begin
          dec_val[4*i +: 4] = val[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_val   = val;
    nxt_cur   = cursor;
    nxt_tick  = tick_cnt;
    nxt_tmo   = tmo_cnt;
    case (state)
      S_IDLE: begin
        nxt_val = '0;
        if (ev_e) begin
          nxt_state = S_SET;
          nxt_cur   = CUR_MAX;
        end
      end
      S_SET: begin
        if (ev_e) begin
          if (val != '0) begin
            nxt_state = S_RUN;
            nxt_tick  = '0;
          end
        end else if (ev_l) begin
          nxt_cur = (cursor == CUR_MAX) ? '0 : cursor + 1'b1;
        end else if (ev_r) begin
          nxt_cur = (cursor == '0) ? CUR_MAX : cursor - 1'b1;
        end else if (ev_u) begin
          nxt_val[4*int'(cursor) +: 4] = (cur_d == cur_lim) ? 4'd0 : cur_d + 4'd1;
        end else if (ev_d) begin
          nxt_val[4*int'(cursor) +: 4] = (cur_d == 4'd0) ? cur_lim : cur_d - 4'd1;
        end
      end
      S_RUN: begin
        if (ev_e) begin
          if (PAUSE_EN != 0) begin
            nxt_state = S_PAUSE;
          end else begin
            nxt_state = S_IDLE;
            nxt_val   = '0;
          end
        end else if (tick_end) begin
          nxt_tick = '0;
          nxt_val  = dec_val;
          if (dec_val == '0) begin
            nxt_state = S_ALARM;
            nxt_tmo   = '0;
          end
        end else begin
          nxt_tick = tick_cnt + 1'b1;
        end
      end
      S_PAUSE: begin
        if (ev_e) nxt_state = S_RUN;
        else if (ev_u) nxt_state = S_SET;
      end
      S_ALARM: begin
        nxt_val = '0;
        if (ev_e) begin
          nxt_state = S_IDLE;
        end else if (ALARM_TMO > 0) begin
          if (tick_end) begin
            nxt_tick = '0;
            if (tmo_cnt == TMO_LAST) begin
              nxt_state = S_IDLE;
              nxt_tmo   = '0;
            end else begin
              nxt_tmo = tmo_cnt + 1'b1;
            end
          end else begin
            nxt_tick = tick_cnt + 1'b1;
          end
        end
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_val   = '0;
      end
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state    <= S_IDLE;
      val      <= '0;
      cursor   <= CUR_MAX;
      tick_cnt <= '0;
      tmo_cnt  <= '0;
      alarm_n  <= 1'b1;
    end else begin
      state    <= nxt_state;
      val      <= nxt_val;
      cursor   <= nxt_cur;
      tick_cnt <= nxt_tick;
      tmo_cnt  <= nxt_tmo;
      alarm_n  <= (nxt_state != S_ALARM);
    end
  end

  assign state_o = state;

  logic [SW-1:0] scan_cnt;
  logic [CW-1:0] scan_idx;
  logic [TW-1:0] blink_cnt;
  logic [7:0]    disp_seg;

  always_comb begin
    disp_seg = seg_lut(val[4*int'(scan_idx) +: 4]);
    if (state == S_SET && scan_idx == cursor && blink_cnt >= TICK_HALF) disp_seg = 8'hFF;
    if (state == S_PAUSE && scan_idx == '0) disp_seg[7] = 1'b0;
  end

  // Select and segments are registered together from the same scan index.
  always_ff @(posedge clkin) begin
    if (rst) begin
      scan_cnt  <= '0;
      scan_idx  <= '0;
      blink_cnt <= '0;
      sel_n     <= '1;
      seg       <= 8'hFF;
    end else begin
      blink_cnt <= (blink_cnt == TICK_MAX) ? '0 : blink_cnt + 1'b1;
      if (scan_cnt == SCAN_MAX) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == '0) ? CUR_MAX : scan_idx - 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      sel_n <= ~(SEL_ONE << scan_idx);
      seg   <= disp_seg;
    end
  end

endmodule

// File: tb/tb_countdown_timer_param.sv
// Directed bench for countdown_timer_param: three instances (plain, mm:ss limits, alarm timeout),
// values recovered from the scanned display and checked against a scoreboard of expected values.
module tb_countdown_timer_param;

  localparam logic [4:0] KE = 5'b10000;
  localparam logic [4:0] KL = 5'b01000;
  localparam logic [4:0] KR = 5'b00100;
  localparam logic [4:0] KU = 5'b00010;
  localparam logic [4:0] KD = 5'b00001;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] kb      [3];
  logic [3:0] sel_n_w [3];
  logic [7:0] seg_w   [3];
  logic       alarm_w [3];
  logic [2:0] state_w [3];

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;

  logic [7:0] disp     [3][4];
  int         blank_at [3][4];

  typedef struct {
    int          inst;
    logic [15:0] val;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  countdown_timer_param #(.NDIG(4), .SCAN_DIV(2), .DEB_CYC(4), .TICK_DIV(10),
    .PAUSE_EN(1), .MMSS_MODE(0), .ALARM_TMO(0)) u0 (
    .clkin(clk), .rst(rst), .ke(kb[0][4]), .ku(kb[0][1]), .kd(kb[0][0]), .kl(kb[0][3]),
    .kr(kb[0][2]), .sel_n(sel_n_w[0]), .seg(seg_w[0]), .alarm_n(alarm_w[0]), .state_o(state_w[0]));

  countdown_timer_param #(.NDIG(4), .SCAN_DIV(2), .DEB_CYC(4), .TICK_DIV(10),
    .PAUSE_EN(1), .MMSS_MODE(1), .ALARM_TMO(0)) u1 (
    .clkin(clk), .rst(rst), .ke(kb[1][4]), .ku(kb[1][1]), .kd(kb[1][0]), .kl(kb[1][3]),
    .kr(kb[1][2]), .sel_n(sel_n_w[1]), .seg(seg_w[1]), .alarm_n(alarm_w[1]), .state_o(state_w[1]));

  countdown_timer_param #(.NDIG(4), .SCAN_DIV(2), .DEB_CYC(4), .TICK_DIV(10),
    .PAUSE_EN(1), .MMSS_MODE(0), .ALARM_TMO(2)) u2 (
    .clkin(clk), .rst(rst), .ke(kb[2][4]), .ku(kb[2][1]), .kd(kb[2][0]), .kl(kb[2][3]),
    .kr(kb[2][2]), .sel_n(sel_n_w[2]), .seg(seg_w[2]), .alarm_n(alarm_w[2]), .state_o(state_w[2]));

  // Capture whatever each digit shows; blanked slots only record when they were seen.
  always @(negedge clk) begin
    logic [3:0] oh;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 4; i++) begin
        oh = 4'b0001 << i;
        if (sel_n_w[j] == ~oh) begin
          if (seg_w[j] == 8'hFF) blank_at[j][i] <= cyc;
          else disp[j][i] <= seg_w[j];
        end
      end
    end
  end

  function automatic logic [3:0] seg2dig(input logic [7:0] s);
    case (s | 8'h80)
      8'hC0: seg2dig = 4'd0;
      8'hF9: seg2dig = 4'd1;
      8'hA4: seg2dig = 4'd2;
      8'hB0: seg2dig = 4'd3;
      8'h99: seg2dig = 4'd4;
      8'h92: seg2dig = 4'd5;
      8'h82: seg2dig = 4'd6;
      8'hF8: seg2dig = 4'd7;
      8'h80: seg2dig = 4'd8;
      8'h90: seg2dig = 4'd9;
      default: seg2dig = 4'hF;
    endcase
  endfunction

  function automatic logic [15:0] disp_val(input int j);
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[4*i +: 4] = seg2dig(disp[j][i]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] im, input logic [4:0] km, input int n);
    for (int j = 0; j < 3; j++) if (im[j]) kb[j] = kb[j] & ~km;
    cycles(n);
    for (int j = 0; j < 3; j++) if (im[j]) kb[j] = 5'h1F;
    cycles(3);
  endtask

  task automatic push(input int j, input logic [15:0] v);
    exp_t e;
    e.inst = j;
    e.val  = v;
    sbq.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, "_sb"}, 32'(sbq.size() != 0), 32'd1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk(tag, 32'(disp_val(e.inst)), 32'(e.val));
    end
  endtask

  // SET-state read: long enough window that the blinking cursor digit shows unblanked.
  task automatic read_set(input string tag, input int j, input logic [3:0] bmask);
    int         t0;
    logic [3:0] m;
    t0 = cyc + 1;
    cycles(40);
    for (int i = 0; i < 4; i++) m[i] = (blank_at[j][i] >= t0);
    chk({tag, "_blank"}, 32'(m), 32'(bmask));
    pop_check(tag);
  endtask

  initial begin
    rst = 1'b1;
    for (int j = 0; j < 3; j++) kb[j] = 5'h1F;
    cycles(3);
    chk("rst_state", 32'(state_w[0]), 32'd0);
    chk("rst_sel", 32'(sel_n_w[0]), 32'hF);
    chk("rst_seg", 32'(seg_w[0]), 32'hFF);
    chk("rst_alarm", 32'(alarm_w[0]), 32'd1);
    rst = 1'b0;
    cycles(2);

    // Alarm auto-timeout on u2: 0001 runs one tick, then two ticks of ALARM.
    press(3'b100, KE, 4);
    press(3'b100, KL, 4);
    press(3'b100, KU, 4);
    push(2, 16'h0001);
    read_set("tmo_set", 2, 4'b0001);
    press(3'b100, KE, 4);
    chk("tmo_run", 32'(state_w[2]), 32'd2);
    cycles(10);
    chk("tmo_alarm", 32'(state_w[2]), 32'd4);
    chk("tmo_alarm_n", 32'(alarm_w[2]), 32'd0);
    cycles(19);
    chk("tmo_hold", 32'(state_w[2]), 32'd4);
    cycles(1);
    chk("tmo_idle", 32'(state_w[2]), 32'd0);
    chk("tmo_alarm_off", 32'(alarm_w[2]), 32'd1);

    // Set 0012 and count it down to the alarm.
    press(3'b001, KE, 4);
    chk("t1_set", 32'(state_w[0]), 32'd1);
    repeat (3) press(3'b001, KR, 4);
    repeat (2) press(3'b001, KU, 4);
    press(3'b001, KL, 4);
    press(3'b001, KU, 4);
    push(0, 16'h0012);
    read_set("t1_val", 0, 4'b0010);
    press(3'b001, KE, 4);
    chk("t1_run", 32'(state_w[0]), 32'd2);
    cycles(19);
    push(0, 16'h0011);
    pop_check("t1_tick1");
    cycles(100);
    chk("t1_pre_alarm", 32'(state_w[0]), 32'd2);
    cycles(1);
    chk("t1_alarm", 32'(state_w[0]), 32'd4);
    chk("t1_alarm_n", 32'(alarm_w[0]), 32'd0);
    press(3'b001, KE, 4);
    chk("t1_idle", 32'(state_w[0]), 32'd0);
    chk("t1_alarm_off", 32'(alarm_w[0]), 32'd1);

    // Digit wraps on u0 (0..9) and u1 (mm:ss), then 0100 runs one tick.
    press(3'b011, KE, 4);
    press(3'b011, KL, 4);
    press(3'b011, KD, 4);
    push(0, 16'h0009);
    read_set("wrap_dn0", 0, 4'b0001);
    press(3'b011, KU, 4);
    push(1, 16'h0000);
    read_set("wrap_up0", 1, 4'b0001);
    press(3'b011, KL, 4);
    press(3'b011, KD, 4);
    push(0, 16'h0090);
    read_set("wrap_dn1", 0, 4'b0010);
    push(1, 16'h0050);
    read_set("wrap_dn1_mmss", 1, 4'b0010);
    press(3'b011, KU, 4);
    press(3'b011, KL, 4);
    press(3'b011, KU, 4);
    push(0, 16'h0100);
    read_set("t2_set", 0, 4'b0100);
    press(3'b011, KE, 4);
    cycles(19);
    push(0, 16'h0099);
    pop_check("t2_borrow");
    push(1, 16'h0059);
    pop_check("t2_borrow_mmss");

    // Synchronous reset in the middle of a run.
    rst = 1'b1;
    cycles(1);
    chk("mid_rst_state", 32'(state_w[0]), 32'd0);
    chk("mid_rst_sel", 32'(sel_n_w[0]), 32'hF);
    chk("mid_rst_seg", 32'(seg_w[0]), 32'hFF);
    chk("mid_rst_alarm", 32'(alarm_w[0]), 32'd1);
    rst = 1'b0;
    cycles(10);
    push(0, 16'h0000);
    pop_check("mid_rst_val");

    // Debounce: too-short press, long press, simultaneous ke+ku.
    press(3'b001, KE, 3);
    cycles(4);
    chk("deb_short", 32'(state_w[0]), 32'd0);
    press(3'b001, KE, 4);
    chk("deb_ok", 32'(state_w[0]), 32'd1);
    press(3'b001, KL, 20);
    push(0, 16'h0000);
    read_set("deb_long", 0, 4'b0001);
    press(3'b001, KE | KU, 4);
    chk("prio_state", 32'(state_w[0]), 32'd1);
    push(0, 16'h0000);
    read_set("prio_val", 0, 4'b0001);

    // Pause at 0007 three cycles into a tick, then resume to the alarm.
    press(3'b001, KD, 4);
    press(3'b001, KD, 4);
    push(0, 16'h0008);
    read_set("p_set", 0, 4'b0001);
    press(3'b001, KE, 4);
    cycles(7);
    press(3'b001, KE, 4);
    chk("p_pause", 32'(state_w[0]), 32'd3);
    push(0, 16'h0007);
    cycles(200);
    chk("p_frozen", 32'(state_w[0]), 32'd3);
    pop_check("p_val");
    chk("p_dp", 32'({disp[0][3][7], disp[0][2][7], disp[0][1][7], disp[0][0][7]}), 32'b1110);
    press(3'b001, KE, 4);
    chk("p_resume", 32'(state_w[0]), 32'd2);
    cycles(66);
    chk("p_pre_alarm", 32'(state_w[0]), 32'd2);
    cycles(1);
    chk("p_alarm", 32'(state_w[0]), 32'd4);
    chk("p_alarm_n", 32'(alarm_w[0]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
